mux_lut_pipe: RTL

Parametrised, pipelined logic unit. Every bit of the result comes from a 4:1 truth-table lookup built from 2:1 multiplexers, so one block produces NAND, NOR, XOR, AND or any other two-input function per bit. It has a bank of run-time-programmable truth tables, a two-stage valid/ready pipeline with back-pressure, and a completed-transaction counter. It replaces fixed single-bit mux-built gates wherever a stream of operand pairs needs a selectable bitwise function.

---
 rtl/mux_lut_pipe.sv | 151 +++++++++++++++
 1 files changed

// File: rtl/mux_lut_pipe.sv
// ---------------------------------------------------------------------------
// mux_lut_pipe
//
// Pipelined bitwise logic unit. Each result bit is a 4:1 truth-table lookup
// built as a two-level tree of 2:1 multiplexers, so any two-input boolean
// function (NAND, NOR, XOR, AND, OR, ...) can be applied per bit. Truth
// tables live in a run-time programmable bank. Operand pairs flow through
// a two-stage valid/ready pipeline with back-pressure, and completed
// transactions are counted.
//
// Parameters
//   WIDTH     operand / result width in bits
//   NBANK     number of truth-table banks (power of two, at least 4)
//   CNTW      width of the completion counter
//
// Ports
//   clk        rising-edge clock
//   rst        asynchronous, active-high reset
//   cfg_we     truth-table write strobe, never blocked
//   cfg_addr   bank to write
//   cfg_tt     truth table, bit index = {a,b} with a as MSB
//   in_valid   operand pair offered
//   in_ready   pair is accepted this cycle
//   in_a/in_b  operands
//   in_bank    bank applied to this pair
//   out_valid  result held
//   out_ready  consumer accepts the result
//   out_y      result
//   done_cnt   completed-transaction count (wraps)
// ---------------------------------------------------------------------------
module mux_lut_pipe #(
    parameter int WIDTH = 8,
    parameter int NBANK = 4,
    parameter int CNTW  = 16
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     cfg_we,
    input  logic [$clog2(NBANK)-1:0] cfg_addr,
    input  logic [3:0]               cfg_tt,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [WIDTH-1:0]         in_a,
    input  logic [WIDTH-1:0]         in_b,
    input  logic [$clog2(NBANK)-1:0] in_bank,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [WIDTH-1:0]         out_y,
    output logic [CNTW-1:0]          done_cnt
);

    // Power-on contents of the truth-table bank.
    function automatic logic [3:0] defaultTable(input int idx);
        case (idx)
            0:       return 4'b0111;
            1:       return 4'b0001;
            2:       return 4'b0110;
            3:       return 4'b1000;
            default: return 4'b0000;
        endcase
    endfunction

    logic [3:0]       r_bank [NBANK];

    logic             r_s1Valid;
    logic [WIDTH-1:0] r_s1A;
    logic [WIDTH-1:0] r_s1B;
    logic [3:0]       r_s1Tt;

    logic             r_s2Valid;
    logic [WIDTH-1:0] r_s2Y;

    logic [CNTW-1:0]  r_doneCnt;

    logic             w_s2Free;
    logic             w_accept;
    logic             w_drain;
    logic [WIDTH-1:0] w_y;

    // S2 can take new data when it is empty or being emptied this cycle,
    // which makes in_ready depend combinationally on out_ready.
    assign w_s2Free = !r_s2Valid || out_ready;
    assign in_ready = !rst && (!r_s1Valid || w_s2Free);
    assign w_accept = in_valid && in_ready;
    assign w_drain  = r_s2Valid && out_ready;

    // Truth-table bank. Writes are independent of the data handshakes; a
    // pair accepted on the same edge reads the old table because the S1
    // snapshot samples the bank before the non-blocking update lands.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int k = 0; k < NBANK; k++) begin
                r_bank[k] <= defaultTable(k);
            end
        end else if (cfg_we) begin
            r_bank[cfg_addr] <= cfg_tt;
        end
    end

    // Stage 1 captures the operands together with a private copy of the
    // selected table so later reprogramming cannot disturb this pair.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_s1Valid <= 1'b0;
            r_s1A     <= '0;
            r_s1B     <= '0;
            r_s1Tt    <= 4'b0000;
        end else if (w_accept) begin
            r_s1Valid <= 1'b1;
            r_s1A     <= in_a;
            r_s1B     <= in_b;
            r_s1Tt    <= r_bank[in_bank];
        end else if (w_s2Free) begin
            r_s1Valid <= 1'b0;
        end
    end

    // Per-bit lookup: b selects within each table half, a selects the half.
    for (genvar i = 0; i < WIDTH; i++) begin : g_bit
        logic w_lo;
        logic w_hi;
        assign w_lo   = r_s1B[i] ? r_s1Tt[1] : r_s1Tt[0];
        assign w_hi   = r_s1B[i] ? r_s1Tt[3] : r_s1Tt[2];
        assign w_y[i] = r_s1A[i] ? w_hi : w_lo;
    end

    // Stage 2 holds the result steady until the consumer takes it.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_s2Valid <= 1'b0;
            r_s2Y     <= '0;
        end else if (w_s2Free) begin
            r_s2Valid <= r_s1Valid;
            r_s2Y     <= w_y;
        end
    end

    // Completion counter, wraps naturally at its width.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_doneCnt <= '0;
        end else if (w_drain) begin
            r_doneCnt <= r_doneCnt + 1'b1;
        end
    end

    assign out_valid = r_s2Valid;
    assign out_y     = r_s2Y;
    assign done_cnt  = r_doneCnt;

endmodule
